// File: rtl/chan_arbiter.sv
// rtl/chan_arbiter.sv - 9-input latched request arbiter with timed grant hold.
// Define CHAN_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with channel 8 highest.
module chan_arbiter #(
  parameter int NREQ = 9,
  parameter int CW   = 4,
  parameter int TMO  = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            mask_wr,
  input  logic [NREQ-1:0] mask_in,
  input  logic            ack,
  output logic            grant_vld,
  output logic [CW-1:0]   chan,
  output logic [NREQ-1:0] grant_oh,
  output logic            busy,
  output logic            timeout_err
);

  localparam logic [CW-1:0] NO_CHAN = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_RELEASE} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_mask;
  logic            r_grant_vld;
  logic [CW-1:0]   r_chan;
  logic [NREQ-1:0] r_grant_oh;
  logic            r_busy;
  logic            r_timeout_err;
  logic [7:0]      r_timer;
  logic [CW-1:0]   r_win;
`ifdef CHAN_ARB_RR_EN
  logic [CW-1:0]   r_ptr;
`endif

  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_new;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_sel_oh;
  logic [NREQ-1:0] w_pend_next;
  logic            w_found;
  logic [CW-1:0]   w_sel;
  logic            w_tmo;
  logic            w_abort;

  assign w_cand   = r_pend & ~r_mask;
  assign w_new    = req & ~r_mask;
  assign w_win_oh = NREQ'(1) << r_win;
  assign w_sel_oh = NREQ'(1) << w_sel;
  assign w_tmo    = (r_timer == 8'(TMO - 1));
  assign w_abort  = (r_state == S_GRANT) && !ack && w_tmo;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
`ifdef CHAN_ARB_RR_EN
    // Descend from the slot below the last winner; the last winner itself comes last.
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_found && w_cand[(int'(r_ptr) + NREQ - i) % NREQ]) begin
        w_found = 1'b1;
        w_sel   = CW'((int'(r_ptr) + NREQ - i) % NREQ);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (w_cand[i]) begin
        w_found = 1'b1;
        w_sel   = CW'(i);
      end
    end
`endif
  end

  // The served channel is resampled on release and dropped on abort; others keep accumulating.
  always_comb begin
    w_pend_next = r_pend | w_new;
    if (r_state == S_RELEASE)
      w_pend_next = (r_pend & ~w_win_oh) | w_new;
    else if (w_abort)
      w_pend_next = w_pend_next & ~w_win_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pend        <= '0;
      r_mask        <= '0;
      r_grant_vld   <= 1'b0;
      r_chan        <= NO_CHAN;
      r_grant_oh    <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
      r_win         <= '0;
`ifdef CHAN_ARB_RR_EN
      r_ptr         <= CW'(NREQ - 1);
`endif
    end else begin
      r_timeout_err <= 1'b0;
      r_pend        <= w_pend_next;
      if (mask_wr)
        r_mask <= mask_in;
      case (r_state)
        S_IDLE: begin
          if (|w_cand) begin
            r_state <= S_ARB;
            r_busy  <= 1'b1;
          end
        end
        S_ARB: begin
          if (w_found) begin
            r_state     <= S_GRANT;
            r_win       <= w_sel;
            r_chan      <= w_sel;
            r_grant_oh  <= w_sel_oh;
            r_grant_vld <= 1'b1;
            r_timer     <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_chan  <= NO_CHAN;
          end
        end
        S_GRANT: begin
          if (ack || w_tmo) begin
            r_state     <= ack ? S_RELEASE : S_IDLE;
            r_busy      <= ack;
            r_grant_vld <= 1'b0;
            r_chan      <= NO_CHAN;
            r_grant_oh  <= '0;
            r_timer     <= '0;
            r_timeout_err <= !ack;
`ifdef CHAN_ARB_RR_EN
            r_ptr       <= r_win;
`endif
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_vld   = r_grant_vld;
  assign chan        = r_chan;
  assign grant_oh    = r_grant_oh;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_chan_arbiter.sv
// tb/tb_chan_arbiter.sv - scoreboard bench for chan_arbiter.
module tb_chan_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req;
  logic       mask_wr;
  logic [8:0] mask_in;
  logic       ack;
  logic       grant_vld;
  logic [3:0] chan;
  logic [8:0] grant_oh;
  logic       busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] sb_q[$];
  logic prev_gv = 1'b0;

  chan_arbiter #(.NREQ(9), .CW(4), .TMO(15)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .grant_vld(grant_vld), .chan(chan), .grant_oh(grant_oh),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every new grant is compared against the next expected channel.
  always @(negedge clk) begin
    if (grant_vld && !prev_gv) begin
      if (sb_q.size() == 0) begin
        check_value("sb_unexpected_grant", {28'd0, chan}, 32'hF);
      end else begin
        logic [3:0] e;
        logic [8:0] eoh;
        e = sb_q.pop_front();
        eoh = 9'd1 << e;
        check_value("sb_chan", {28'd0, chan}, {28'd0, e});
        check_value("sb_grant_oh", {23'd0, grant_oh}, {23'd0, eoh});
      end
    end
    prev_gv = grant_vld;
  end

  task automatic wait_grant();
    int n;
    n = 0;
    while (!grant_vld && n < 40) begin
      tick();
      n++;
    end
    check_value("grant_seen", {31'd0, grant_vld}, 32'd1);
  endtask

  task automatic serve(input logic drop_req);
    wait_grant();
    repeat (2) tick();
    ack = 1'b1;
    if (drop_req) req = '0;
    tick();
    ack = 1'b0;
    check_value("rel_grant_vld", {31'd0, grant_vld}, 32'd0);
    check_value("rel_chan", {28'd0, chan}, 32'hF);
    check_value("rel_grant_oh", {23'd0, grant_oh}, 32'd0);
  endtask

  task automatic write_mask(input logic [8:0] m);
    mask_wr = 1'b1;
    mask_in = m;
    tick();
    mask_wr = 1'b0;
  endtask

  initial begin
    int cnt;
    logic seen;
    rst = 1'b1; req = '0; mask_wr = 1'b0; mask_in = '0; ack = 1'b0;
    repeat (3) tick();
    check_value("rst_grant_vld", {31'd0, grant_vld}, 32'd0);
    check_value("rst_chan", {28'd0, chan}, 32'hF);
    check_value("rst_grant_oh", {23'd0, grant_oh}, 32'd0);
    check_value("rst_busy", {31'd0, busy}, 32'd0);
    check_value("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;

    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || grant_vld || grant_oh != 0 || chan != 4'hF) seen = 1'b1;
    end
    check_value("idle_quiet", {31'd0, seen}, 32'd0);

    // Held level on channels 5 and 0; dropped when the third grant is acked.
`ifdef CHAN_ARB_RR_EN
    sb_q.push_back(4'd5); sb_q.push_back(4'd0); sb_q.push_back(4'd5); sb_q.push_back(4'd0);
`else
    sb_q.push_back(4'd5); sb_q.push_back(4'd5); sb_q.push_back(4'd5); sb_q.push_back(4'd0);
`endif
    req = 9'h021;
    serve(1'b0);
    serve(1'b0);
    serve(1'b1);
    serve(1'b0);
    repeat (5) tick();
    check_value("after_021_busy", {31'd0, busy}, 32'd0);

    // Timeout abort.
    sb_q.push_back(4'd8);
    req = 9'h100;
    tick();
    req = '0;
    wait_grant();
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!grant_vld) break;
      cnt++;
    end
    check_value("tmo_grant_cycles", cnt, 32'd15);
    check_value("tmo_err_pulse", {31'd0, timeout_err}, 32'd1);
    tick();
    check_value("tmo_err_single", {31'd0, timeout_err}, 32'd0);
    repeat (10) tick();
    check_value("tmo_pend_cleared", {31'd0, busy}, 32'd0);

    // Ack on the last allowed cycle wins over the timeout.
    sb_q.push_back(4'd8);
    req = 9'h100;
    tick();
    req = '0;
    wait_grant();
    repeat (14) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_value("tie_no_err", {31'd0, timeout_err}, 32'd0);
    check_value("tie_grant_vld", {31'd0, grant_vld}, 32'd0);
    tick();
    check_value("tie_no_err_late", {31'd0, timeout_err}, 32'd0);
    repeat (5) tick();

    // Masked channel 8 loses to 7 and is never latched.
    sb_q.push_back(4'd7);
    write_mask(9'h100);
    req = 9'h180;
    serve(1'b1);
    repeat (10) tick();
    check_value("mask8_idle", {31'd0, busy}, 32'd0);
    write_mask(9'h000);

    // Mask change during a grant does not revoke it.
    sb_q.push_back(4'd3);
    req = 9'h008;
    wait_grant();
    sb_q.push_back(4'd8);
    req = 9'h108;
    write_mask(9'h008);
    check_value("held_grant_vld", {31'd0, grant_vld}, 32'd1);
    check_value("held_chan", {28'd0, chan}, 32'd3);
    tick();
    ack = 1'b1;
    req = '0;
    tick();
    ack = 1'b0;
    check_value("held_rel_vld", {31'd0, grant_vld}, 32'd0);
    serve(1'b0);
    repeat (5) tick();
    check_value("after_mask_busy", {31'd0, busy}, 32'd0);

    // Reset during a grant; ack afterwards is ignored and the mask is gone.
    write_mask(9'h002);
    sb_q.push_back(4'd4);
    req = 9'h010;
    wait_grant();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check_value("mid_rst_grant_vld", {31'd0, grant_vld}, 32'd0);
    check_value("mid_rst_chan", {28'd0, chan}, 32'hF);
    check_value("mid_rst_grant_oh", {23'd0, grant_oh}, 32'd0);
    check_value("mid_rst_busy", {31'd0, busy}, 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (5) tick();
    check_value("post_rst_idle", {31'd0, busy}, 32'd0);
    sb_q.push_back(4'd1);
    req = 9'h002;
    tick();
    req = '0;
    serve(1'b0);
    repeat (5) tick();

    check_value("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chan_arbiter.md
Name: chan_arbiter

Overview:
- Sequencing controller for the 9-input channel-code path: latches up to 9 interrupt/channel requests and arbitrates one winner at a time.
- Presents the winner as a 4-bit channel code and a one-hot grant, then holds the grant until the requester acknowledges or a timeout expires.
- Sits between the raw request lines and the downstream service logic that consumes the channel code.

Parameters:
- NREQ, 9, number of request lines; the design is verified at 9 only.
- CW, 4, channel code width; must satisfy 2^CW > NREQ.
- TMO, 15, maximum cycles in GRANT without ack before abort; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req  input  NREQ  level request per channel.
- mask_wr  input  1  load mask_in into the mask register this cycle.
- mask_in  input  NREQ  new mask value; 1 = channel blocked.
- ack  input  1  service-complete strobe from the granted requester.
- grant_vld  output  1  high while a grant is held.
- chan  output  CW  winning channel index 0..8; 4'hF when no grant.
- grant_oh  output  NREQ  one-hot grant; all zero when no grant.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse on grant abort.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, pend=0, mask=0, grant_vld=0, chan=4'hF, grant_oh=0, busy=0, timeout_err=0, timer=0; the round-robin pointer (when compiled in) resets to 8.
- Pending register: every cycle, pend <= pend | (req & ~mask), except where a RELEASE or abort clear applies.
  - Masked requests are never latched.
  - Bits already pending stay pending if masked later.
- Mask:
  - mask_wr updates the mask on the next edge.
  - A mask change only affects future arbitrations; a held grant is never revoked by the mask.
- Arbitration (fixed priority): candidate set = pend & ~mask; the highest index wins, so channel 8 has top priority.
- States:
  - IDLE: if candidates != 0, go to ARB; else stay.
  - ARB (1 cycle):
    - Register the winner into chan/grant_oh and go to GRANT.
    - If candidates became 0 because of a mask change, return to IDLE with chan=4'hF.
  - GRANT:
    - grant_vld=1; timer counts up from 0.
    - If ack is high, go to RELEASE.
    - Else, when timer==TMO-1, abort: pend[win] cleared, timeout_err=1 for one cycle, next state IDLE.
    - If ack and timeout occur in the same cycle, ack wins and there is no error.
  - RELEASE (1 cycle):
    - grant_vld=0, chan=4'hF, grant_oh=0.
    - pend[win] <= req[win] & ~mask[win] (fresh sample; a still-asserted level re-queues the channel).
    - Next state IDLE.
- Latency:
  - req first sampled at edge k sets pend after k.
  - State is ARB after k+1; grant_vld and chan are valid after edge k+2.
  - Minimum spacing between back-to-back grants is 4 cycles (GRANT, RELEASE, IDLE, ARB).
- ack outside GRANT is ignored.
- req changes during GRANT only accumulate into pend.
- rst asserted mid-grant returns all outputs to reset values on that edge; pend and mask are cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CHAN_ARB_RR_EN.
- Defined: round-robin arbitration.
  - ptr holds the last winner.
  - The search starts at ptr-1 and descends, wrapping from 0 to NREQ-1; ptr itself is checked last.
  - ptr updates on entry to RELEASE or abort.
- Undefined: fixed priority as above; no ptr register exists.

Test Plan:
- Reset, then req=9'h000 for 20 cycles -> busy=0, chan=4'hF, grant_oh=0, grant_vld never high.
- req=9'h021 held, ack 2 cycles after each grant -> first grant chan=5 (grant_oh=9'h020).
  - Fixed mode: chan=5 repeats while req is held.
  - RR mode: next grant is chan=0.
- req=9'h100 pulse for 1 cycle, ack withheld, TMO=15 -> grant_vld high exactly 15 cycles, timeout_err pulses once, pend[8] cleared, return to IDLE.
- mask_in=9'h100 written, then req=9'h180 -> chan=7; req bit 8 never granted while masked.
- During a grant of chan=3, raise req[8] and mask_wr with mask_in=9'h008 -> chan 3 grant continues to ack; next grant is chan=8.
- rst pulsed while grant_vld=1 -> next cycle grant_vld=0, chan=4'hF, pend=0, mask=0; ack arriving after reset is ignored.
